// File: rtl/bist_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bist_scheduler_if : requester / pulse-controller signal bundle for bist_scheduler
// Rev 1.0
// ============================================================================
interface bist_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 8
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] err;
   logic               ctl_start;
   logic               ctl_running;
   logic               ctl_bist_end;
   logic               busy;
   logic [CNT_W-1:0]   session_cnt;

   modport slave (
      input  req, ctl_running, ctl_bist_end,
      output gnt, done, err, ctl_start, busy, session_cnt
   );

   modport master (
      output req, ctl_running, ctl_bist_end,
      input  gnt, done, err, ctl_start, busy, session_cnt
   );
endinterface
`default_nettype wire

// File: rtl/bist_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bist_scheduler : round-robin sharing of one BIST pulse controller
// Rev 1.0
// ============================================================================
module bist_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input wire logic        clk,
   input wire logic        reset,
   bist_scheduler_if.slave bus
);
   localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [PTR_W-1:0] C_PTR_RST = PTR_W'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START    = 3'd1,
      S_WAIT_RUN = 3'd2,
      S_WAIT_END = 3'd3,
      S_DONE     = 3'd4,
      S_ERROR    = 3'd5
   } state_t;

   state_t             r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_done;
   logic [NUM_REQ-1:0] r_err;
   logic               r_start;
   logic               r_busy;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_timer;
   logic [PTR_W-1:0]   r_ptr;

   logic               w_found;
   logic [PTR_W-1:0]   w_winner;
   logic [PTR_W-1:0]   w_cand;
   logic [NUM_REQ-1:0] w_onehot;
   int                 w_idx;

   // Search starts just above the last winner so a held request yields to others.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = 0;
      w_cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx  = (int'(r_ptr) + k) % NUM_REQ;
         w_cand = PTR_W'(w_idx);
         if (!w_found && bus.req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
      w_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_done  <= '0;
         r_err   <= '0;
         r_start <= 1'b0;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_timer <= '0;
         r_ptr   <= C_PTR_RST;
      end else begin
         r_done  <= '0;
         r_err   <= '0;
         r_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_gnt   <= w_onehot;
                  r_ptr   <= w_winner;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_timer <= '0;
               r_state <= S_WAIT_RUN;
            end
            S_WAIT_RUN: begin
               if (bus.ctl_running) begin
                  r_timer <= '0;
                  r_state <= S_WAIT_END;
               end else if (r_timer == C_TIMEOUT) begin
                  r_err   <= r_gnt;
                  r_gnt   <= '0;
                  r_state <= S_ERROR;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_WAIT_END: begin
               // Only reached after running was seen, so a stale bist_end cannot end the session.
               if (!bus.ctl_running && bus.ctl_bist_end) begin
                  r_done  <= r_gnt;
                  r_gnt   <= '0;
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= S_DONE;
               end else if (r_timer == C_TIMEOUT) begin
                  r_err   <= r_gnt;
                  r_gnt   <= '0;
                  r_state <= S_ERROR;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_DONE, S_ERROR: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt         = r_gnt;
   assign bus.done        = r_done;
   assign bus.err         = r_err;
   assign bus.ctl_start   = r_start;
   assign bus.busy        = r_busy;
   assign bus.session_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bist_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_bist_scheduler : directed self-checking bench for bist_scheduler
// Rev 1.0
// ============================================================================
module tb_bist_scheduler;
   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 8;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [CNT_W-1:0] exp_cnt;

   always #50 clk = ~clk;

   bist_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

   bist_scheduler #(
      .NUM_REQ (NUM_REQ),
      .TIMEOUT (255),
      .CNT_W   (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      bus.req          = '0;
      bus.ctl_running  = 1'b0;
      bus.ctl_bist_end = 1'b0;
      repeat (2) @(negedge clk);
      reset   = 1'b0;
      exp_cnt = '0;
   endtask

   task automatic wait_start(input int limit, output int waited);
      int n;
      n = 0;
      waited = -1;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (bus.ctl_start) begin
            waited = n;
            break;
         end
      end
   endtask

   // Controller model: running one cycle after start, low at run_len with bist_end set.
   task automatic run_session(input string tag, input logic [3:0] exp_gnt, input int run_len,
                              input int drop_at, output int lat);
      int k;
      wait_start(20, lat);
      chk_eq({tag, "_start_seen"}, 32'(lat > 0), 32'd1);
      if (lat > 0) begin
         chk_eq({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
         bus.ctl_running  = 1'b1;
         bus.ctl_bist_end = 1'b0;
         if (drop_at == 0) bus.req = '0;
         k = 0;
         while (k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1) chk_eq({tag, "_start_one_cycle"}, 32'(bus.ctl_start), 32'd0);
            if (k == drop_at) bus.req = '0;
            if (k == run_len) begin
               bus.ctl_running  = 1'b0;
               bus.ctl_bist_end = 1'b1;
            end
            if (bus.done != '0 || bus.err != '0) break;
         end
         exp_cnt++;
         chk_eq({tag, "_done"}, 32'(bus.done), 32'(exp_gnt));
         chk_eq({tag, "_no_err"}, 32'(bus.err), 32'd0);
         chk_eq({tag, "_gnt_clear"}, 32'(bus.gnt), 32'd0);
         chk_eq({tag, "_cnt"}, 32'(bus.session_cnt), 32'(exp_cnt));
         @(negedge clk);
         chk_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int k;
      int starts;
      logic [3:0] g;

      // Reset values
      reset            = 1'b1;
      bus.req          = '0;
      bus.ctl_running  = 1'b0;
      bus.ctl_bist_end = 1'b0;
      exp_cnt          = '0;
      repeat (3) @(negedge clk);
      chk_eq("rst_gnt", 32'(bus.gnt), 32'd0);
      chk_eq("rst_start", 32'(bus.ctl_start), 32'd0);
      chk_eq("rst_busy", 32'(bus.busy), 32'd0);
      chk_eq("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
      chk_eq("rst_cnt", 32'(bus.session_cnt), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk_eq("idle_no_req_busy", 32'(bus.busy), 32'd0);

      // Single request with nominal 90-cycle controller
      bus.req = 4'b0001;
      run_session("single", 4'b0001, 90, 0, lat);
      chk_eq("single_latency", 32'(lat), 32'd1);
      chk_eq("single_idle_busy", 32'(bus.busy), 32'd0);

      // All requesters held: round-robin order
      do_reset();
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         g = 4'b0001 << (i % 4);
         run_session($sformatf("rr%0d", i), g, 8, (i == 4) ? 0 : -1, lat);
      end
      chk_eq("rr_cnt5", 32'(bus.session_cnt), 32'd5);
      @(negedge clk);
      chk_eq("rr_idle_after", 32'(bus.busy), 32'd0);

      // Run timeout: running never rises (rr_ptr=0, only req0 pending)
      bus.req = 4'b0001;
      wait_start(20, lat);
      chk_eq("to_gnt", 32'(bus.gnt), 32'd1);
      bus.req = '0;
      bus.ctl_running  = 1'b0;
      bus.ctl_bist_end = 1'b0;
      k = 0;
      while (k < 400) begin
         @(negedge clk);
         k++;
         if (bus.err != '0 || bus.done != '0) break;
      end
      chk_eq("to_cycles", 32'(k), 32'd257);
      chk_eq("to_err", 32'(bus.err), 32'd1);
      chk_eq("to_no_done", 32'(bus.done), 32'd0);
      chk_eq("to_cnt_kept", 32'(bus.session_cnt), 32'd5);
      @(negedge clk);
      chk_eq("to_err_pulse", 32'(bus.err), 32'd0);
      chk_eq("to_idle", 32'(bus.busy), 32'd0);

      // Stale bist_end left high by a previous session
      bus.req = 4'b0010;
      run_session("prev", 4'b0010, 10, 0, lat);
      bus.req = 4'b0100;
      wait_start(20, lat);
      chk_eq("stale_gnt", 32'(bus.gnt), 32'b0100);
      bus.req = '0;
      repeat (10) @(negedge clk);
      chk_eq("stale_no_done", 32'(bus.done), 32'd0);
      chk_eq("stale_busy", 32'(bus.busy), 32'd1);
      bus.ctl_running = 1'b1;
      repeat (5) @(negedge clk);
      chk_eq("stale_running_no_done", 32'(bus.done), 32'd0);
      bus.ctl_running = 1'b0;
      k = 0;
      while (k < 10) begin
         @(negedge clk);
         k++;
         if (bus.done != '0) break;
      end
      exp_cnt++;
      chk_eq("stale_done_lat", 32'(k), 32'd1);
      chk_eq("stale_done", 32'(bus.done), 32'b0100);
      chk_eq("stale_cnt", 32'(bus.session_cnt), 32'(exp_cnt));

      // Mid-session reset 20 cycles into WAIT_END
      @(negedge clk);
      bus.req = 4'b0001;
      wait_start(20, lat);
      chk_eq("mrst_gnt", 32'(bus.gnt), 32'd1);
      bus.ctl_running  = 1'b1;
      bus.ctl_bist_end = 1'b0;
      bus.req          = '0;
      repeat (22) @(negedge clk);
      #10 reset = 1'b1;
      #1;
      chk_eq("mrst_gnt0", 32'(bus.gnt), 32'd0);
      chk_eq("mrst_start0", 32'(bus.ctl_start), 32'd0);
      chk_eq("mrst_busy0", 32'(bus.busy), 32'd0);
      chk_eq("mrst_cnt0", 32'(bus.session_cnt), 32'd0);
      bus.ctl_running = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_eq("mrst_no_pulse", 32'({bus.done, bus.err}), 32'd0);
      reset   = 1'b0;
      exp_cnt = '0;
      bus.req = 4'b0010;
      run_session("post_rst", 4'b0010, 20, 0, lat);

      // Withdrawn request mid-session
      bus.req = 4'b0100;
      run_session("withdraw", 4'b0100, 30, 5, lat);
      starts = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.ctl_start) starts++;
      end
      chk_eq("withdraw_no_regrant", 32'(starts), 32'd0);
      chk_eq("withdraw_gnt0", 32'(bus.gnt), 32'd0);
      chk_eq("withdraw_idle", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
